// File: rtl/multicycle_control.sv
// Multicycle instruction controller: sequences fetch, decode, execute,
// memory and writeback for an RV32I-style datapath. It also keeps a sticky
// illegal/timeout trap and a retired-instruction counter.
package cpu_package;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_function_t;
  typedef enum logic [2:0] {R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE} instruction_type_t;
endpackage

module multicycle_control
  import cpu_package::*;
#(
  parameter int XLEN        = 32,
  parameter int BRANCH_LT   = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instruction,
  input  logic              alu_equal,
  input  logic              alu_less,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic              ir_write,
  output logic              reg_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output alu_function_t     alu_control,
  output instruction_type_t instruction_type,
  output logic [XLEN-1:0]   imm,
  output logic              illegal,
  output logic              mem_error,
  output logic [XLEN-1:0]   retired
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP} state_t;

  state_t            state_q;
  logic [31:0]       ir_q;
  logic [XLEN-1:0]   imm_q, retired_q;
  alu_function_t     alu_q, alu_d;
  instruction_type_t type_q, type_d;
  logic              illegal_q, mem_error_q;
  logic [WW-1:0]     wait_q;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              legal, taken, is_store, is_mem, wait_tick, timeout;
  logic signed [31:0] imm32;

  assign opcode   = ir_q[6:0];
  assign funct3   = ir_q[14:12];
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = (opcode == OP_LOAD) || is_store;

  // ALU function shared by op and op-imm; alt selects sub/sra
  function automatic alu_function_t arith_alu(input logic [2:0] f3, input logic alt, input logic allow_sub);
    case (f3)
      3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Decode of the latched instruction: format, immediate, ALU function, legality
  always_comb begin
    imm32  = '0;
    type_d = R_TYPE;
    alu_d  = ALU_ADD;
    legal  = 1'b1;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        type_d = I_TYPE;
        imm32  = {{20{ir_q[31]}}, ir_q[31:20]};
      end
      OP_IMM: begin
        type_d = I_TYPE;
        imm32  = {{20{ir_q[31]}}, ir_q[31:20]};
        alu_d  = arith_alu(funct3, ir_q[30], 1'b0);
      end
      OP_STORE: begin
        type_d = S_TYPE;
        imm32  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      end
      OP_BRANCH: begin
        type_d = B_TYPE;
        imm32  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        alu_d  = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        // 010/011 are unassigned; the ordered compares are optional hardware
        if (funct3[2:1] == 2'b01) legal = 1'b0;
        if (funct3[2] && (BRANCH_LT == 0)) legal = 1'b0;
      end
      OP_LUI: begin
        type_d = U_TYPE;
        imm32  = {ir_q[31:12], 12'b0};
        alu_d  = ALU_PASS_B;
      end
      OP_AUIPC: begin
        type_d = U_TYPE;
        imm32  = {ir_q[31:12], 12'b0};
      end
      OP_JAL: begin
        type_d = J_TYPE;
        imm32  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      end
      OP_OP: begin
        type_d = R_TYPE;
        alu_d  = arith_alu(funct3, ir_q[30], 1'b1);
      end
      default: legal = 1'b0;
    endcase
  end

  // Branch outcome from the ALU flags
  always_comb begin
    case (funct3)
      3'b000:         taken = alu_equal;
      3'b001:         taken = !alu_equal;
      3'b100, 3'b110: taken = alu_less;
      3'b101, 3'b111: taken = !alu_less;
      default:        taken = 1'b0;
    endcase
  end

  // Strobes decoded from state; reset leaves only the fetch request visible
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
      end
      S_EXECUTE: if (opcode == OP_BRANCH) begin
        pc_write = 1'b1;
        pc_src   = taken ? 2'd1 : 2'd0;
      end
      S_MEMORY: begin
        mem_req  = 1'b1;
        mem_we   = is_store;
        pc_write = is_store && mem_ready;
      end
      S_WRITEBACK: begin
        reg_write = (ir_q[11:7] != 5'd0);
        pc_write  = 1'b1;
        pc_src    = (opcode == OP_JAL) ? 2'd1 : (opcode == OP_JALR) ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
    if (reset) begin
      mem_we    = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      mem_req   = (state_q == S_FETCH);
    end
  end

  // A ready in the limit cycle still completes, so the timeout needs ready low
  assign wait_tick = mem_req && !mem_ready;
  assign timeout   = wait_tick && (wait_q == WW'(MEM_TIMEOUT - 1));

  // Main sequencer with its registered decode results, flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      ir_q        <= '0;
      imm_q       <= '0;
      alu_q       <= ALU_ADD;
      type_q      <= R_TYPE;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
      wait_q      <= '0;
      retired_q   <= '0;
    end else begin
      if (pc_write)  retired_q <= retired_q + XLEN'(1);
      if (wait_tick) wait_q    <= wait_q + WW'(1);
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= instruction;
            state_q <= S_DECODE;
          end else if (timeout) begin
            mem_error_q <= 1'b1;
            state_q     <= S_TRAP;
          end
        end
        S_DECODE: begin
          imm_q  <= XLEN'(imm32);
          alu_q  <= alu_d;
          type_q <= type_d;
          if (legal) begin
            state_q <= S_EXECUTE;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= S_TRAP;
          end
        end
        S_EXECUTE: begin
          if (opcode == OP_BRANCH) begin
            wait_q  <= '0;
            state_q <= S_FETCH;
          end else if (is_mem) begin
            wait_q  <= '0;
            state_q <= S_MEMORY;
          end else begin
            state_q <= S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          if (mem_ready) begin
            if (is_store) begin
              wait_q  <= '0;
              state_q <= S_FETCH;
            end else begin
              state_q <= S_WRITEBACK;
            end
          end else if (timeout) begin
            mem_error_q <= 1'b1;
            state_q     <= S_TRAP;
          end
        end
        S_WRITEBACK: begin
          wait_q  <= '0;
          state_q <= S_FETCH;
        end
        default: state_q <= S_TRAP;
      endcase
    end
  end

  assign alu_control      = alu_q;
  assign instruction_type = type_q;
  assign imm              = imm_q;
  assign illegal          = illegal_q;
  assign mem_error        = mem_error_q;
  assign retired          = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a default instance (XLEN=32,
// BRANCH_LT=1, MEM_TIMEOUT=16) and a small one (XLEN=8, BRANCH_LT=0,
// MEM_TIMEOUT=4) share the same stimulus.
module tb_multicycle_control;
  import cpu_package::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = '0;
  logic        alu_equal = 1'b0, alu_less = 1'b0, mem_ready = 1'b0;

  logic mem_req0, mem_we0, ir_write0, reg_write0, pc_write0, illegal0, mem_error0;
  logic mem_req1, mem_we1, ir_write1, reg_write1, pc_write1, illegal1, mem_error1;
  logic [1:0] pc_src0, pc_src1;
  alu_function_t alu0, alu1;
  instruction_type_t typ0, typ1;
  logic [31:0] imm0, retired0;
  logic [7:0]  imm1, retired1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut0 (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_equal(alu_equal),
    .alu_less(alu_less), .mem_ready(mem_ready), .mem_req(mem_req0), .mem_we(mem_we0),
    .ir_write(ir_write0), .reg_write(reg_write0), .pc_write(pc_write0), .pc_src(pc_src0),
    .alu_control(alu0), .instruction_type(typ0), .imm(imm0), .illegal(illegal0),
    .mem_error(mem_error0), .retired(retired0)
  );

  multicycle_control #(.XLEN(8), .BRANCH_LT(0), .MEM_TIMEOUT(4)) dut1 (
    .clk(clk), .reset(reset), .instruction(instruction), .alu_equal(alu_equal),
    .alu_less(alu_less), .mem_ready(mem_ready), .mem_req(mem_req1), .mem_we(mem_we1),
    .ir_write(ir_write1), .reg_write(reg_write1), .pc_write(pc_write1), .pc_src(pc_src1),
    .alu_control(alu1), .instruction_type(typ1), .imm(imm1), .illegal(illegal1),
    .mem_error(mem_error1), .retired(retired1)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive inputs just after the falling edge, then settle
  task automatic cyc(input logic rdy, input logic [31:0] ins);
    @(negedge clk);
    reset       = 1'b0;
    mem_ready   = rdy;
    instruction = ins;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    mem_ready   = 1'b0;
    instruction = '0;
    alu_equal   = 1'b0;
    alu_less    = 1'b0;
    #1;
  endtask

  function automatic logic [4:0] strobes0();
    return {mem_req0, mem_we0, ir_write0, reg_write0, pc_write0};
  endfunction
  function automatic logic [4:0] strobes1();
    return {mem_req1, mem_we1, ir_write1, reg_write1, pc_write1};
  endfunction

  int we_cycles;

  initial begin
    // reset state
    do_reset();
    cyc(1'b0, 32'h0);
    check("rst_imm", imm0, 0);
    check("rst_retired", retired0, 0);
    check("rst_illegal", illegal0, 0);
    check("rst_mem_error", mem_error0, 0);
    check("rst_pc_src", pc_src0, 0);
    check("rst_fetch_req", mem_req0, 1);

    // addi x1,x0,5
    do_reset();
    cyc(1'b1, 32'h00500093);
    check("addi_c1_irw", ir_write0, 1);
    check("addi_c1_req", mem_req0, 1);
    cyc(1'b0, 32'h0);
    check("addi_c2_strobes", strobes0(), 5'b0);
    cyc(1'b0, 32'h0);
    check("addi_c3_strobes", strobes0(), 5'b0);
    check("addi_imm", imm0, 5);
    check("addi_imm8", imm1, 5);
    check("addi_alu", alu0, ALU_ADD);
    check("addi_type", typ0, I_TYPE);
    cyc(1'b0, 32'h0);
    check("addi_c4_regw", reg_write0, 1);
    check("addi_c4_pcw", pc_write0, 1);
    check("addi_c4_pcsrc", pc_src0, 0);
    cyc(1'b0, 32'h0);
    check("addi_retired", retired0, 1);
    check("addi_back_fetch", mem_req0, 1);

    // negative immediate sign extension and lui
    do_reset();
    cyc(1'b1, 32'hFFF00093); cyc(1'b0, 0); cyc(1'b0, 0);
    check("addi_m1_imm", imm0, 32'hFFFF_FFFF);
    check("addi_m1_imm8", imm1, 8'hFF);
    do_reset();
    cyc(1'b1, 32'h123450B7); cyc(1'b0, 0); cyc(1'b0, 0);
    check("lui_imm", imm0, 32'h1234_5000);
    check("lui_alu", alu0, ALU_PASS_B);
    check("lui_type", typ0, U_TYPE);

    // beq taken then not taken, each three cycles
    do_reset();
    alu_equal = 1'b1;
    cyc(1'b1, 32'h00000063);
    check("beq_t_irw", ir_write0, 1);
    cyc(1'b0, 0);
    check("beq_t_decode", strobes0(), 5'b0);
    cyc(1'b0, 0);
    check("beq_t_pcw", pc_write0, 1);
    check("beq_t_pcsrc", pc_src0, 1);
    check("beq_t_type", typ0, B_TYPE);
    alu_equal = 1'b0;
    cyc(1'b1, 32'h00000063);
    check("beq_t_fetch", {mem_req0, ir_write0}, 2'b11);
    check("beq_t_retired", retired0, 1);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    check("beq_n_pcw", pc_write0, 1);
    check("beq_n_pcsrc", pc_src0, 0);
    cyc(1'b0, 0);
    check("beq_n_retired", retired0, 2);

    // blt: legal on dut0, illegal on dut1
    do_reset();
    alu_less = 1'b1;
    cyc(1'b1, 32'h00004063); cyc(1'b0, 0); cyc(1'b0, 0);
    check("blt_pcsrc", {pc_write0, pc_src0}, 3'b101);
    check("blt_illegal0", illegal0, 0);
    check("blt_nlt_illegal", illegal1, 1);
    check("blt_nlt_strobes", strobes1(), 5'b0);

    // bge not taken when less
    do_reset();
    alu_less = 1'b1;
    cyc(1'b1, 32'h00005063); cyc(1'b0, 0); cyc(1'b0, 0);
    check("bge_pcsrc", {pc_write0, pc_src0}, 3'b100);

    // funct3 010 branch is illegal everywhere
    do_reset();
    cyc(1'b1, 32'h00002063); cyc(1'b0, 0); cyc(1'b0, 0);
    check("br010_illegal", {illegal0, illegal1}, 2'b11);

    // illegal opcode: trap holds for 20 cycles
    do_reset();
    cyc(1'b1, 32'h0000007F); cyc(1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      alu_equal = i[0];
      cyc(1'b1, 32'h0000007F);
      check("trap_strobes", {strobes0(), strobes1()}, 10'b0);
      check("trap_illegal", {illegal0, illegal1, mem_error0}, 3'b110);
    end

    // sw with three wait cycles in MEMORY
    do_reset();
    cyc(1'b1, 32'h00112023); cyc(1'b0, 0); cyc(1'b0, 0);
    check("sw_exec_strobes", strobes0(), 5'b0);
    check("sw_imm", imm0, 0);
    check("sw_type", typ0, S_TYPE);
    we_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0);
      if (mem_we0) we_cycles++;
      check("sw_wait_pcw", pc_write0, 0);
    end
    cyc(1'b1, 0);
    if (mem_we0) we_cycles++;
    check("sw_ready_pcw", {pc_write0, pc_src0, reg_write0}, 4'b1000);
    check("sw_ready_pcw8", pc_write1, 1);
    cyc(1'b0, 0);
    check("sw_we_cycles", we_cycles, 4);
    check("sw_done", {mem_we0, retired0[3:0], mem_error1}, 6'b0_0001_0);

    // lw then writeback
    do_reset();
    cyc(1'b1, 32'h0000A083); cyc(1'b0, 0); cyc(1'b0, 0);
    cyc(1'b1, 0);
    check("lw_mem", {mem_req0, mem_we0, pc_write0}, 3'b100);
    cyc(1'b0, 0);
    check("lw_wb", {reg_write0, pc_write0, pc_src0}, 4'b1100);

    // jal / jalr (rd=0) writeback
    do_reset();
    cyc(1'b1, 32'h000000EF); cyc(1'b0, 0); cyc(1'b0, 0); cyc(1'b0, 0);
    check("jal_wb", {reg_write0, pc_write0, pc_src0}, 4'b1101);
    do_reset();
    cyc(1'b1, 32'h00008067); cyc(1'b0, 0); cyc(1'b0, 0); cyc(1'b0, 0);
    check("jalr_wb", {reg_write0, pc_write0, pc_src0}, 4'b0110);

    // fetch timeout on the small instance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0);
      check("to_wait_req", {mem_req1, mem_error1}, 2'b10);
    end
    cyc(1'b0, 0);
    check("to_error", {mem_error1, mem_req1}, 2'b10);
    check("to_dut0_ok", {mem_error0, mem_req0}, 2'b01);

    // ready in the limit cycle wins
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b0, 0);
    cyc(1'b1, 32'h00500093);
    check("to_edge_irw", ir_write1, 1);
    cyc(1'b0, 0);
    check("to_edge_noerr", {mem_error1, mem_req1, illegal1}, 3'b000);

    // reset in the middle of a MEMORY wait
    do_reset();
    cyc(1'b1, 32'h00500093); cyc(1'b0, 0); cyc(1'b0, 0); cyc(1'b0, 0);
    cyc(1'b1, 32'h00112023); cyc(1'b0, 0); cyc(1'b0, 0);
    cyc(1'b0, 0); cyc(1'b0, 0);
    check("mid_mem_we", {mem_req0, mem_we0}, 2'b11);
    check("mid_retired", retired0, 1);
    do_reset();
    check("mid_rst_cycle", strobes0(), 5'b0);
    cyc(1'b0, 0);
    check("mid_after_rst", {mem_req0, mem_we0, illegal0, mem_error0}, 4'b1000);
    check("mid_after_retired", retired0, 0);

    // retired wraps on the 8-bit instance
    do_reset();
    alu_equal = 1'b1;
    for (int n = 0; n < 256; n++) begin
      cyc(1'b1, 32'h00000063); cyc(1'b0, 0); cyc(1'b0, 0);
      if (n == 254) begin
        cyc(1'b0, 0);
        check("wrap_255", retired1, 8'd255);
        cyc(1'b1, 32'h00000063); cyc(1'b0, 0); cyc(1'b0, 0);
        break;
      end
    end
    cyc(1'b0, 0);
    check("wrap_0", retired1, 8'd0);
    check("wrap_256_wide", retired0, 256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
